// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the TotalALU command front end: function codes, FSM
// encoding, command record and code-classification helpers.
package alu_issue_ctrl_pkg;

  localparam logic [5:0] OpNop  = 6'd0;
  localparam logic [5:0] OpSrl  = 6'd2;
  localparam logic [5:0] OpMfhi = 6'd16;
  localparam logic [5:0] OpMflo = 6'd18;
  localparam logic [5:0] OpDivu = 6'd27;
  localparam logic [5:0] OpAdd  = 6'd32;
  localparam logic [5:0] OpSub  = 6'd34;
  localparam logic [5:0] OpAnd  = 6'd36;
  localparam logic [5:0] OpOr   = 6'd37;
  localparam logic [5:0] OpSlt  = 6'd42;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExec   = 2'd1,
    StMuldiv = 2'd2,
    StResp   = 2'd3
  } state_t;

  // 70-bit FIFO entry.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
  } cmd_t;

  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OpAnd, OpOr, OpAdd, OpSub, OpSlt, OpSrl, OpDivu, OpMfhi, OpMflo: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_muldiv(input logic [5:0] op);
    return op == OpDivu;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO with full/empty flags; the pointers
// carry one wrap bit so full and empty are distinguishable.
module alu_cmd_fifo
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_t         mem [DEPTH];
  logic [AW:0]  wrPtrQ;
  logic [AW:0]  rdPtrQ;

  assign empty = (wrPtrQ == rdPtrQ);
  assign full  = (wrPtrQ[AW] != rdPtrQ[AW]) && (wrPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);
  assign rdata = mem[rdPtrQ[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
    end else begin
      if (push && !full) begin
        mem[wrPtrQ[AW-1:0]] <= wdata;
        wrPtrQ              <= wrPtrQ + 1'b1;
      end
      if (pop && !empty) begin
        rdPtrQ <= rdPtrQ + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// In-order issue controller in front of TotalALU. Optional statistics counters
// are enabled with the ALU_ISSUE_STATS_EN macro.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [5:0]  cmd_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_stall
`endif
);

  localparam int unsigned CntW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  state_t          stateQ;
  logic [CntW-1:0] countQ;
  logic [31:0]     aluAQ;
  logic [31:0]     aluBQ;
  logic [5:0]      aluSignalQ;
  logic            resValidQ;
  logic [31:0]     resDataQ;
  logic            resErrQ;

  cmd_t headCmd;
  cmd_t newCmd;
  logic fifoFull;
  logic fifoEmpty;
  logic fifoPop;

  assign newCmd  = '{a: cmd_a, b: cmd_b, op: cmd_op};
  assign fifoPop = (stateQ == StExec) || ((stateQ == StMuldiv) && (countQ == '0));

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clk  (clk),
    .reset(reset),
    .push (cmd_valid),
    .wdata(newCmd),
    .pop  (fifoPop),
    .rdata(headCmd),
    .full (fifoFull),
    .empty(fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= StIdle;
      countQ     <= '0;
      aluAQ      <= '0;
      aluBQ      <= '0;
      aluSignalQ <= OpNop;
      resValidQ  <= 1'b0;
      resDataQ   <= '0;
      resErrQ    <= 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (!fifoEmpty) begin
            if (is_muldiv(headCmd.op)) begin
              stateQ <= StMuldiv;
              countQ <= CntW'(MULDIV_CYCLES - 1);
            end else begin
              stateQ <= StExec;
            end
            // Unsupported codes still pass through EXEC, but with NOP on the bus.
            if (is_supported(headCmd.op)) begin
              aluAQ      <= headCmd.a;
              aluBQ      <= headCmd.b;
              aluSignalQ <= headCmd.op;
            end
          end
        end
        StExec: begin
          resDataQ   <= is_supported(headCmd.op) ? alu_result : '0;
          resErrQ    <= !is_supported(headCmd.op);
          resValidQ  <= 1'b1;
          aluAQ      <= '0;
          aluBQ      <= '0;
          aluSignalQ <= OpNop;
          stateQ     <= StResp;
        end
        StMuldiv: begin
          if (countQ == '0) begin
            resDataQ   <= '0;
            resErrQ    <= 1'b0;
            resValidQ  <= 1'b1;
            aluAQ      <= '0;
            aluBQ      <= '0;
            aluSignalQ <= OpNop;
            stateQ     <= StResp;
          end else begin
            countQ <= countQ - 1'b1;
          end
        end
        StResp: begin
          if (res_ready) begin
            resValidQ <= 1'b0;
            stateQ    <= StIdle;
          end
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = !fifoFull;
  assign alu_a      = aluAQ;
  assign alu_b      = aluBQ;
  assign alu_signal = aluSignalQ;
  assign res_valid  = resValidQ;
  assign res_data   = resDataQ;
  assign res_err    = resErrQ;
  assign busy       = (stateQ != StIdle) || !fifoEmpty;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] statIssuedQ;
  logic [31:0] statStallQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      statIssuedQ <= '0;
      statStallQ  <= '0;
    end else begin
      if (fifoPop) statIssuedQ <= statIssuedQ + 32'd1;
      if (cmd_valid && fifoFull) statStallQ <= statStallQ + 32'd1;
    end
  end

  assign stat_issued = statIssuedQ;
  assign stat_stall  = statStallQ;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural TotalALU (incl. HI/LO)
// hung off the alu_* bus.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [5:0]  cmd_op = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_signal;
  logic [31:0] alu_result;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stall;
`endif

  int nChecks = 0;
  int nPass = 0;
  int divCycles = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_signal(alu_signal),
    .alu_result(alu_result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_stall (stat_stall)
`endif
  );

  // Behavioural TotalALU: combinational ops, HI/LO written while DIVU is held.
  logic [31:0] hiReg = '0;
  logic [31:0] loReg = '0;

  always @(posedge clk) begin
    if (reset) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (alu_signal == 6'd27 && alu_b != 0) begin
      hiReg <= alu_a % alu_b;
      loReg <= alu_a / alu_b;
    end
  end

  always_comb begin
    alu_result = '0;
    case (alu_signal)
      6'd36: alu_result = alu_a & alu_b;
      6'd37: alu_result = alu_a | alu_b;
      6'd32: alu_result = alu_a + alu_b;
      6'd34: alu_result = alu_a - alu_b;
      6'd42: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      6'd2:  alu_result = alu_a >> alu_b[4:0];
      6'd16: alu_result = hiReg;
      6'd18: alu_result = loReg;
      default: alu_result = '0;
    endcase
  end

  always @(negedge clk) begin
    if (alu_signal == 6'd27) divCycles++;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushCmd(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Waits for a response (bounded), records it, then lets res_ready consume it.
  task automatic waitResp(output logic [31:0] data, output logic err, output int waited);
    waited = 0;
    while (!res_valid && waited < 100) begin
      tick();
      waited++;
    end
    if (!res_valid) checkVal("resp_timeout", 32'd0, 32'd1);
    data = res_data;
    err  = res_err;
    tick();
  endtask

  logic [31:0] d;
  logic        e;
  int          w;

  initial begin
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkVal("rst_cmd_ready", cmd_ready, 1);
    checkVal("rst_res_valid", res_valid, 0);
    checkVal("rst_res_data", res_data, 0);
    checkVal("rst_res_err", res_err, 0);
    checkVal("rst_alu_a", alu_a, 0);
    checkVal("rst_alu_b", alu_b, 0);
    checkVal("rst_alu_signal", alu_signal, 0);
    checkVal("rst_busy", busy, 0);

    // ADD 5+7: EXEC one cycle after push, res_valid two cycles after.
    res_ready = 1'b1;
    pushCmd(32'd5, 32'd7, 6'd32);
    checkVal("add_t1_valid", res_valid, 0);
    checkVal("add_t1_busy", busy, 1);
    tick();
    checkVal("add_exec_signal", alu_signal, 32);
    checkVal("add_exec_a", alu_a, 5);
    checkVal("add_exec_b", alu_b, 7);
    tick();
    checkVal("add_valid", res_valid, 1);
    checkVal("add_data", res_data, 12);
    checkVal("add_err", res_err, 0);
    checkVal("add_resp_signal", alu_signal, 0);
    tick();
    checkVal("add_done_valid", res_valid, 0);
    checkVal("add_done_busy", busy, 0);

    // SLT with backpressure; the queued ADD must wait for res_ready.
    res_ready = 1'b0;
    pushCmd(32'd3, 32'd9, 6'd42);
    pushCmd(32'd1, 32'd1, 6'd32);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkVal("slt_hold_valid", res_valid, 1);
      checkVal("slt_hold_data", res_data, 1);
      checkVal("slt_hold_signal", alu_signal, 0);
      tick();
    end
    res_ready = 1'b1;
    checkVal("slt_hold_data_last", res_data, 1);
    tick();
    checkVal("slt_released_valid", res_valid, 0);
    checkVal("slt_idle_signal", alu_signal, 0);
    tick();
    checkVal("add2_exec_signal", alu_signal, 32);
    tick();
    checkVal("add2_data", res_data, 2);
    checkVal("add2_valid", res_valid, 1);
    tick();

    // DIVU 100/7 then MFLO, MFHI.
    divCycles = 0;
    pushCmd(32'd100, 32'd7, 6'd27);
    pushCmd(32'd0, 32'd0, 6'd18);
    pushCmd(32'd0, 32'd0, 6'd16);
    waitResp(d, e, w);
    checkVal("divu_latency", w, 31);
    checkVal("divu_data", d, 0);
    checkVal("divu_err", e, 0);
    waitResp(d, e, w);
    checkVal("mflo_data", d, 14);
    waitResp(d, e, w);
    checkVal("mfhi_data", d, 2);
    checkVal("divu_hold_cycles", divCycles, 32);

    // Fill FIFO: one command in RESP plus DEPTH queued.
    res_ready = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      checkVal("fill_ready", cmd_ready, 1);
      pushCmd(32'(i), 32'd10, 6'd32);
    end
    checkVal("full_not_ready", cmd_ready, 0);
    res_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      waitResp(d, e, w);
      checkVal("drain_data", d, 32'(10 + i));
    end
    checkVal("drain_ready", cmd_ready, 1);

    // Unsupported code, then an unaffected ADD.
    pushCmd(32'd1, 32'd2, 6'd63);
    pushCmd(32'd4, 32'd5, 6'd32);
    checkVal("bad_exec_signal", alu_signal, 0);
    checkVal("bad_exec_a", alu_a, 0);
    waitResp(d, e, w);
    checkVal("bad_data", d, 0);
    checkVal("bad_err", e, 1);
    waitResp(d, e, w);
    checkVal("after_bad_data", d, 9);
    checkVal("after_bad_err", e, 0);

    // Reset mid-DIVU.
    pushCmd(32'd100, 32'd7, 6'd27);
    for (int i = 0; i < 10; i++) tick();
    checkVal("mid_div_signal", alu_signal, 27);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkVal("rst_div_busy", busy, 0);
    checkVal("rst_div_valid", res_valid, 0);
    checkVal("rst_div_signal", alu_signal, 0);
    checkVal("rst_div_ready", cmd_ready, 1);
    pushCmd(32'd0, 32'd0, 6'd18);
    waitResp(d, e, w);
    checkVal("rst_mflo_data", d, 0);
    checkVal("rst_mflo_err", e, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command front end that sits directly upstream of the TotalALU datapath: it buffers ALU commands (operands plus 6-bit function code) from the decode stage and drives `dataA`/`dataB`/`Signal` into TotalALU. It holds DIVU stable for the full multi-cycle divide and captures `Output` into a registered result port with a valid/ready handshake. Commands issue strictly in order, one at a time, so MFHI/MFLO always observe the HI/LO produced by every earlier DIVU.

## Interface
- `DEPTH`, 4 — command FIFO entries, power of two, ≥2
- `MULDIV_CYCLES`, 32 — cycles `Signal`=DIVU is held before HI/LO are treated as valid
- `clk` input 1 — single clock, rising edge
- `reset` input 1 — synchronous, active-high; clears FIFO, FSM, result register
- `cmd_valid` input 1 — command offered
- `cmd_ready` output 1 — FIFO not full
- `cmd_a` input 32 — operand A
- `cmd_b` input 32 — operand B
- `cmd_op` input 6 — function code: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, DIVU 27, MFHI 16, MFLO 18
- `alu_a` output 32 — to TotalALU `dataA`
- `alu_b` output 32 — to TotalALU `dataB`
- `alu_signal` output 6 — to TotalALU `Signal`
- `alu_result` input 32 — from TotalALU `Output`
- `res_valid` output 1 — result held
- `res_ready` input 1 — consumer accepts
- `res_data` output 32 — captured result
- `res_err` output 1 — command had an unsupported code
- `busy` output 1 — FSM not in IDLE or FIFO not empty

## Operation
- FIFO push on `cmd_valid && cmd_ready`. Simultaneous push and pop while full is not allowed: `cmd_ready` depends only on the full flag.
- FSM states are IDLE, EXEC, MULDIV and RESP. The head entry drives `alu_a`/`alu_b`/`alu_signal` during EXEC and MULDIV only. In IDLE and RESP the outputs are 0/0/6'b000000 (NOP).
- IDLE:
  - FIFO empty → stay in IDLE.
  - Head is DIVU → MULDIV, counter loaded with `MULDIV_CYCLES-1`.
  - Head is any other code → EXEC.
- EXEC: one cycle. `alu_result` is registered into `res_data`, `res_err`=0, head is popped → RESP.
- MULDIV: operands and DIVU are held. The counter decrements each cycle. At 0: `res_data`=0, `res_err`=0, pop → RESP.
- Unsupported code: IDLE → EXEC with NOP driven, `res_data`=0, `res_err`=1.
- RESP: `res_valid`=1. On `res_ready` → IDLE. `res_data`/`res_err` stay stable while `res_valid && !res_ready`.
- Reset in any state, including mid-MULDIV: IDLE, FIFO empty, counter 0. TotalALU shares `reset`, so partial HI/LO state is discarded.

## Timing
- Reset values: `cmd_ready`=1, `res_valid`=0, `res_data`=0, `res_err`=0, `alu_a`=0, `alu_b`=0, `alu_signal`=0, `busy`=0.
- Single-cycle op, empty FIFO: push at edge t → EXEC during cycle t+1 → `res_valid` high from t+2.
- DIVU: push at t → MULDIV for cycles t+1 … t+MULDIV_CYCLES → `res_valid` from t+MULDIV_CYCLES+1.
- Back-to-back throughput is 3 cycles per single-cycle op when `res_ready` is held high: EXEC, RESP, IDLE.
- `cmd_ready` deasserts the cycle after the DEPTH-th unpopped push. It reasserts the cycle after a pop.
- `alu_result` is sampled only at the end of EXEC; TotalALU is treated as combinational for these codes.

## Configuration
- `ALU_ISSUE_STATS_EN` defined: adds `stat_issued` (32-bit output, count of popped commands) and `stat_stall` (32-bit output, cycles with `cmd_valid && !cmd_ready`). Both clear on `reset` and wrap at 2^32.
- `ALU_ISSUE_STATS_EN` undefined: neither port nor counter exists. Behaviour is otherwise identical.

## Structure
- The shared package holds:
  - the nine function-code constants and NOP (6'b000000);
  - the FSM state encoding (2 bits);
  - the `is_supported(op)` and `is_muldiv(op)` helper functions.
- One sub-module, `alu_cmd_fifo`: DEPTH×70-bit synchronous FIFO with full/empty flags and a synchronous-reset pointer clear. The FSM, counter and result register stay in the top module.

## Test plan
- ADD 5+7, `res_ready`=1 → `res_data`=12, `res_err`=0, `res_valid` 2 cycles after push.
- SLT a=3, b=9, with `res_ready` held low 4 cycles → `res_data`=1 held stable; `alu_signal`=0 during RESP; next command not issued until `res_ready`.
- DIVU 100/7, then MFLO, then MFHI → responses 0, 14, 2; `alu_signal`=27 for exactly 32 cycles.
- Push 5 commands with `res_ready`=0 → `cmd_ready` low after the 4th FIFO entry plus 1 in RESP; resuming drains all results in order.
- `cmd_op`=6'd63 → `res_err`=1, `res_data`=0; the following ADD is unaffected.
- Reset asserted at cycle 10 of a DIVU → next cycle IDLE, `busy`=0, `res_valid`=0; a fresh MFLO returns 0.
